// File: rtl/shift_scheduler_pkg.sv
// rtl/shift_scheduler_pkg.sv - shared types and op codes for the shift scheduler
package shift_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_ILL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  function automatic logic is_illegal(input logic [1:0] fun);
    return fun == SH_ILL;
  endfunction

endpackage

// File: rtl/shift_scheduler_rr_arbiter.sv
// rtl/shift_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Grants the first set request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// rtl/shift_scheduler.sv - shares one combinational shifter among NREQ requesters
// Round-robin grant, one cycle on the shared shifter, registered result on a valid/ready channel.
module shift_scheduler
  import shift_scheduler_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_fun,
  output logic [WIDTH-1:0]      sh_A,
  output logic [WIDTH-1:0]      sh_B,
  output logic [1:0]            sh_fun,
  input  logic [WIDTH-1:0]      sh_S,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] win_a, win_b;
  logic [1:0]       win_fun;
  logic [WIDTH-1:0] op_a, op_b, hold_a, hold_b;
  logic [1:0]       op_fun, hold_fun;
  logic [IDW-1:0]   op_id;
  logic             take, exec, rsp_hs;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(gnt_any)
  );

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_fun = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_a   = req_a[i*WIDTH +: WIDTH];
        win_b   = req_b[i*WIDTH +: WIDTH];
        win_fun = req_fun[i*2 +: 2];
      end
    end
  end

  assign take   = (state == ST_IDLE) && gnt_any;
  assign exec   = (state == ST_EXEC);
  assign rsp_hs = (state == ST_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_any)   state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are forced low during reset so no grant or response leaks out of a reset cycle.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: req_ready = gnt;
        ST_RESP: rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      op_fun <= '0;
      op_id  <= '0;
    end else if (take) begin
      op_a   <= win_a;
      op_b   <= win_b;
      op_fun <= win_fun;
      op_id  <= gnt_idx;
    end
  end

  // The shifter sees the op only in EXEC and otherwise keeps its last inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a   <= '0;
      hold_b   <= '0;
      hold_fun <= '0;
    end else if (exec) begin
      hold_a   <= op_a;
      hold_b   <= op_b;
      hold_fun <= op_fun;
    end
  end

  assign sh_A   = exec ? op_a   : hold_a;
  assign sh_B   = exec ? op_b   : hold_b;
  assign sh_fun = exec ? op_fun : hold_fun;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (exec) begin
      rsp_id   <= op_id;
      rsp_err  <= is_illegal(op_fun);
      rsp_data <= is_illegal(op_fun) ? '0 : sh_S;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr <= '0;
    else if (rsp_hs) ptr <= (op_id == IDW'(NREQ-1)) ? '0 : op_id + 1'b1;
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// tb/tb_shift_scheduler.sv - self-checking bench for shift_scheduler
module tb_shift_scheduler;
  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*2-1:0]     req_fun;
  logic [WIDTH-1:0]      sh_A, sh_B, sh_S, rsp_data;
  logic [1:0]            sh_fun;
  logic                  rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]        rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  always #5 clk = ~clk;

  shift_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .sh_A(sh_A), .sh_B(sh_B), .sh_fun(sh_fun), .sh_S(sh_S),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // external shift unit
  always_comb begin
    case (sh_fun)
      2'b00:   sh_S = sh_B << sh_A[4:0];
      2'b01:   sh_S = sh_B >> sh_A[4:0];
      2'b11:   sh_S = $signed(sh_B) >>> sh_A[4:0];
      default: sh_S = 32'hDEADBEEF;
    endcase
  end

  // bit-by-bit expected result
  function automatic logic [31:0] exp_shift(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic [31:0] r;
    int n, src;
    r = '0;
    n = int'(a[4:0]);
    if (f == 2'b10) return 32'h0;
    for (int i = 0; i < WIDTH; i++) begin
      src = (f == 2'b00) ? i - n : i + n;
      if (src >= 0 && src < WIDTH) r[i] = b[src];
      else                         r[i] = (f == 2'b11) ? b[WIDTH-1] : 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_fun[i*2 +: 2]       = f;
    req_valid[i]            = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0; g = -1;
    for (int c = 0; c < 12 && !ok; c++) begin
      #1;
      if (req_ready != 0) begin ok = 1'b1; g = (req_ready == 2'b10) ? 1 : 0; end
      else tick();
    end
  endtask

  task automatic wait_rsp(input int clr, output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick(); lat++;
      if (lat == 1) req_valid[clr] = 1'b0;
      #1;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic one_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                        output int g, output int lat, output bit ok);
    bit okg, okr;
    put(i, a, b, f);
    wait_grant(g, okg);
    wait_rsp(i, lat, okr);
    ok = okg && okr;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %h expected 0", rsp_id); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (sh_A !== 32'h0 || sh_B !== 32'h0 || sh_fun !== 2'b00) begin n_fail++; $display("FAIL reset_sh: got %h %h %b expected 0 0 00", sh_A, sh_B, sh_fun); end
    req_valid = '0; rsp_ready = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sll();
    int g, lat; bit ok;
    one_op(0, 32'd31, 32'h00000001, 2'b00, g, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sll_timeout: got no response expected one"); end
    n_checks++; if (g != 0) begin n_fail++; $display("FAIL sll_grant: got %0d expected 0", g); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sll_latency: got %0d expected 2", lat); end
    n_checks++; if (rsp_data !== 32'h80000000) begin n_fail++; $display("FAIL sll_data: got %h expected 80000000", rsp_data); end
    n_checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL sll_id_err: got %h %b expected 0 0", rsp_id, rsp_err); end
    finish_rsp(); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sll_release: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_sra_srl();
    int g, lat; bit ok;
    one_op(1, 32'd4, 32'h80000000, 2'b11, g, lat, ok);
    n_checks++; if (!ok || g != 1) begin n_fail++; $display("FAIL sra_grant: got %0d ok=%0d expected 1", g, ok); end
    n_checks++; if (rsp_data !== 32'hF8000000) begin n_fail++; $display("FAIL sra_data: got %h expected f8000000", rsp_data); end
    n_checks++; if (rsp_id !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL sra_id_err: got %h %b expected 1 0", rsp_id, rsp_err); end
    finish_rsp();
    one_op(0, 32'h24, 32'hF0000000, 2'b01, g, lat, ok);
    n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL srl_grant: got %0d ok=%0d expected 0", g, ok); end
    n_checks++; if (rsp_data !== 32'h0F000000) begin n_fail++; $display("FAIL srl_data: got %h expected 0f000000", rsp_data); end
    n_checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL srl_id_err: got %h %b expected 0 0", rsp_id, rsp_err); end
    finish_rsp();
  endtask

  task automatic test_illegal();
    int g, lat; bit ok;
    one_op(1, 32'd5, 32'h12345678, 2'b10, g, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ill_timeout: got no response expected one"); end
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b expected 1", rsp_err); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL ill_data: got %h expected 0", rsp_data); end
    finish_rsp();
    one_op(0, 32'd8, 32'h12345678, 2'b00, g, lat, ok);
    n_checks++; if (!ok || lat != 2) begin n_fail++; $display("FAIL ill_next_lat: got %0d ok=%0d expected 2", lat, ok); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL ill_next_err: got %b expected 0", rsp_err); end
    n_checks++; if (rsp_data !== 32'h34567800) begin n_fail++; $display("FAIL ill_next_data: got %h expected 34567800", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int g, lat; bit ok;
    logic [31:0] e0, e1;
    e0 = exp_shift(32'd3, 32'hA5A50001, 2'b01);
    e1 = exp_shift(32'd17, 32'h8000F00F, 2'b11);
    one_op(0, 32'd3, 32'hA5A50001, 2'b01, g, lat, ok);
    put(1, 32'd17, 32'h8000F00F, 2'b11);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no response expected one"); end
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, rsp_valid); end
      n_checks++; if (rsp_data !== e0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%h expected %h/0", c, rsp_data, rsp_id, e0); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", c, req_ready); end
    end
    finish_rsp(); #1;
    n_checks++; if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_grant: got %b/%b expected 10/0", req_ready, rsp_valid); end
    wait_rsp(1, lat, ok);
    n_checks++; if (!ok || rsp_data !== e1 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_waiter: got %h/%h expected %h/1", rsp_data, rsp_id, e1); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int g, lat; bit ok;
    one_op(0, 32'd1, 32'h1, 2'b00, g, lat, ok);
    finish_rsp();
    one_op(1, 32'd2, 32'hFFFF0000, 2'b01, g, lat, ok);
    n_checks++; if (!ok || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_reach_resp: got %b expected 1", rsp_valid); end
    reset = 1'b1;
    tick(); #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rm_resp_reset: got %b %h %h expected 0 0 0", rsp_valid, rsp_data, rsp_id); end
    reset = 1'b0;
    tick(); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_resp_after: got %b expected 0", rsp_valid); end
    put(0, 32'd3, 32'h7, 2'b00);
    put(1, 32'd3, 32'h9, 2'b00);
    wait_grant(g, ok);
    n_checks++; if (!ok || g != 0) begin n_fail++; $display("FAIL rm_first_grant: got %0d expected 0", g); end
    tick();
    reset = 1'b1;
    tick(); #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rm_exec_reset: got %b %b expected 0 00", rsp_valid, req_ready); end
    n_checks++; if (sh_A !== 32'h0 || sh_B !== 32'h0) begin n_fail++; $display("FAIL rm_exec_sh: got %h %h expected 0 0", sh_A, sh_B); end
    req_valid = '0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_exec_after[%0d]: got %b expected 0", c, rsp_valid); end
    end
  endtask

  task automatic test_fairness();
    int order[4] = '{0, 1, 0, 1};
    exp_t q[$];
    exp_t e;
    logic [31:0] pa[2], pb[2];
    logic [1:0]  pf[2];
    int ng = 0, nr = 0, clr = -1, gi;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = $urandom; pb[i] = $urandom; pf[i] = 2'(i); put(i, pa[i], pb[i], pf[i]);
    end
    for (int c = 0; c < 60 && nr < 4; c++) begin
      if (clr >= 0) begin
        pa[clr] = $urandom; pb[clr] = $urandom; pf[clr] = 2'b11; put(clr, pa[clr], pb[clr], pf[clr]); clr = -1;
      end
      #1;
      if (req_ready != 0 && ng < 4) begin
        gi = (req_ready == 2'b10) ? 1 : 0;
        n_checks++; if (gi != order[ng]) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", ng, gi, order[ng]); end
        e.id = gi; e.data = exp_shift(pa[gi], pb[gi], pf[gi]); e.err = 1'b0;
        q.push_back(e); ng++; clr = gi;
      end
      if (rsp_valid && q.size() > 0) begin
        e = q.pop_front();
        n_checks++; if (int'(rsp_id) != order[nr] || rsp_data !== e.data) begin n_fail++; $display("FAIL fair_rsp[%0d]: got %0d/%h expected %0d/%h", nr, rsp_id, rsp_data, order[nr], e.data); end
        nr++;
      end
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
    n_checks++; if (nr != 4) begin n_fail++; $display("FAIL fair_count: got %0d expected 4", nr); end
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [31:0] pa[2], pb[2];
    logic [1:0]  pf[2];
    bit pv[2];
    int clr = -1, mptr = 0, done = 0, gexp;
    do_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int c = 0; c < 1500 && done < 24; c++) begin
      if (clr >= 0) begin req_valid[clr] = 1'b0; pv[clr] = 1'b0; clr = -1; end
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pa[i] = $urandom; pb[i] = $urandom; pf[i] = 2'($urandom_range(0, 3));
          pv[i] = 1'b1; put(i, pa[i], pb[i], pf[i]);
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (req_ready != 0) begin
        gexp = -1;
        for (int k = 0; k < NREQ; k++) if (gexp < 0 && pv[(mptr + k) % NREQ]) gexp = (mptr + k) % NREQ;
        n_checks++;
        if (gexp < 0 || req_ready !== (NREQ'(1) << gexp) || q.size() != 0) begin
          n_fail++; $display("FAIL rnd_grant: got %b expected grant %0d with nothing in flight (%0d)", req_ready, gexp, q.size());
        end
        if (gexp >= 0) begin
          e.id = gexp; e.data = exp_shift(pa[gexp], pb[gexp], pf[gexp]); e.err = (pf[gexp] == 2'b10);
          q.push_back(e); clr = gexp;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_rsp: got unexpected response id %0d expected none", rsp_id);
        end else begin
          e = q.pop_front();
          if (int'(rsp_id) != e.id || rsp_data !== e.data || rsp_err !== e.err) begin
            n_fail++; $display("FAIL rnd_rsp: got %0d/%h/%b expected %0d/%h/%b", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
          end
          mptr = (e.id + 1) % NREQ;
        end
        done++;
      end
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
    n_checks++; if (done != 24) begin n_fail++; $display("FAIL rnd_count: got %0d expected 24", done); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_fun = '0; rsp_ready = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
